switch_debouncer: RTL and testbench

Synchronizing, counter-based debouncer for a single mechanical input such as a push-button or DIP switch. It sits between a raw board input pin and logic that needs a clean, glitch-free level. The top level uses it to turn the centre push-button into the system reset request. It also produces one-cycle rise and fall pulses aligned with each change of the debounced level.

---
 rtl/switch_debouncer.sv | 90 +++++++++
 tb/tb_switch_debouncer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Counter-based debouncer for one mechanical input, with one-cycle rise/fall pulses.
// Define DEBOUNCER_SYNC_EN for a two-flop input synchronizer; otherwise a single sample register is used.
module switch_debouncer #(
    parameter int unsigned WIDTH = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic in_i,
    output logic out_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             cand;
    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic             out_q,  out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

`ifdef DEBOUNCER_SYNC_EN
    logic s1_q, s2_q;

    // Sampling runs regardless of enable_i so the synchronizer never goes stale.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= in_i;
            s2_q <= s1_q;
        end
    end

    assign cand = s2_q;
`else
    logic s_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q <= 1'b0;
        end else begin
            s_q <= in_i;
        end
    end

    assign cand = s_q;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (enable_i) begin
            if (cand == out_q) begin
                // A bounce back to the current level discards the partial count.
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d  = '0;
                out_d  = cand;
                rise_d = cand;
                fall_d = ~cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out_o  = out_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with WIDTH=4; expected latencies follow DEBOUNCER_SYNC_EN.
module tb_switch_debouncer;

    localparam int W = 4;
`ifdef DEBOUNCER_SYNC_EN
    localparam int LAT = (1 << W) + 2;
`else
    localparam int LAT = (1 << W) + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic in  = 1'b1;
    logic out_w, rise_w, fall_w;

    int tests = 0;
    int fails = 0;

    switch_debouncer #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .enable_i(en),
        .in_i    (in),
        .out_o   (out_w),
        .rise_o  (rise_w),
        .fall_o  (fall_w)
    );

    always #5 clk = ~clk;

    // Advance n rising edges; outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic o, input logic r, input logic f);
        check({tag, ".out"},  out_w,  o);
        check({tag, ".rise"}, rise_w, r);
        check({tag, ".fall"}, fall_w, f);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in  = 1'b0;
        en  = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset held with in=1 for 5 cycles
        rst = 1'b1;
        in  = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_all("reset_hold", 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        in  = 1'b0;
        tick(1);
        check_all("reset_release", 1'b0, 1'b0, 1'b0);

        // Clean press and release
        do_reset();
        tick(2);
        in = 1'b1;
        tick(LAT - 1);
        check_all("press_before", 1'b0, 1'b0, 1'b0);
        tick(1);
        check_all("press_edge", 1'b1, 1'b1, 1'b0);
        tick(1);
        check_all("press_after", 1'b1, 1'b0, 1'b0);
        tick(3);
        check_all("press_hold", 1'b1, 1'b0, 1'b0);
        in = 1'b0;
        tick(LAT - 1);
        check_all("release_before", 1'b1, 1'b0, 1'b0);
        tick(1);
        check_all("release_edge", 1'b0, 1'b0, 1'b1);
        tick(1);
        check_all("release_after", 1'b0, 1'b0, 1'b0);

        // Bounce: toggle every 5 cycles for 40 cycles, then hold high
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            in = (seg % 2 == 0) ? 1'b1 : 1'b0;
            for (int c = 0; c < 5; c++) begin
                tick(1);
                check("bounce_out", out_w, 1'b0);
                check("bounce_rise", rise_w, 1'b0);
            end
        end
        in = 1'b1;
        tick(LAT - 1);
        check_all("bounce_before", 1'b0, 1'b0, 1'b0);
        tick(1);
        check_all("bounce_edge", 1'b1, 1'b1, 1'b0);

        // Enable gap of 7 cycles after edge 8
        do_reset();
        in = 1'b1;
        tick(8);
        en = 1'b0;
        tick(7);
        check_all("gap_paused", 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        tick(LAT + 7 - 15 - 1);
        check_all("gap_before", 1'b0, 1'b0, 1'b0);
        tick(1);
        check_all("gap_edge", 1'b1, 1'b1, 1'b0);
        tick(1);
        check_all("gap_after", 1'b1, 1'b0, 1'b0);

        // Enable low holds the debounced level even when input changes for long
        en = 1'b0;
        in = 1'b0;
        tick(LAT + 4);
        check_all("en_low_hold", 1'b1, 1'b0, 1'b0);
        en = 1'b1;
        in = 1'b1;
        tick(2);

        // Reset pulsed at edge 10 mid-count
        do_reset();
        in = 1'b1;
        tick(9);
        rst = 1'b1;
        tick(1);
        check_all("midrst_edge", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(LAT - 1);
        check_all("midrst_before", 1'b0, 1'b0, 1'b0);
        tick(1);
        check_all("midrst_edge_out", 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
